alu_mul_sequencer: RTL and testbench

// - Owns ALU input-side control (OPX, SRCX, DIN, CCL_LD) and shares it between the core decoder and an internal multiplier.
// - Runs a 16x16->32 shift-add multiply by issuing one ALU ADD per cycle; sits between decode and the ALU wrapper.
// - Core traffic passes straight through when idle; core is stalled while a multiply owns the ALU.

---
 rtl/alu_mul_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shares ALU input-side control between the core decoder and a 16x16->32 shift-add multiplier.
// Optional signed mode is enabled by defining MUL_SIGNED_EN.
module alu_mul_sequencer #(
    parameter logic [3:0] ALU_OP_ADD = 4'b0000,
    parameter logic [1:0] ASRC_DIN   = 2'b00,
    parameter logic [2:0] BSRC_DIN   = 3'b000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CORE_VALID,
    input  logic [3:0]  CORE_OPX,
    input  logic [1:0]  CORE_ASRCX,
    input  logic [2:0]  CORE_BSRCX,
    input  logic [15:0] CORE_ADIN,
    input  logic [15:0] CORE_BDIN,
    input  logic        CORE_CCL_LD,
    output logic        CORE_STALL,
    input  logic        MUL_START,
    input  logic        MUL_SIGNED,
    input  logic [15:0] MUL_A,
    input  logic [15:0] MUL_B,
    output logic        MUL_BUSY,
    output logic        MUL_DONE,
    output logic [15:0] MUL_HI,
    output logic [15:0] MUL_LO,
    output logic [3:0]  ALU_OPX,
    output logic [1:0]  ALUA_SRCX,
    output logic [2:0]  ALUB_SRCX,
    output logic [15:0] ALUA_DIN,
    output logic [15:0] ALUB_DIN,
    output logic        CCL_LD,
    input  logic [15:0] ALU_R
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] p_hi_q, p_hi_d;
    logic [15:0] p_lo_q, p_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;

    logic [15:0] a_load;
    logic [15:0] b_load;
    logic        neg_load;
    logic        carry;
    logic [31:0] prod_raw;
    logic [31:0] prod_fin;

`ifdef MUL_SIGNED_EN
    // Magnitudes go through the unsigned datapath; 16'h8000 stays 16'h8000 as unsigned.
    always_comb begin
        a_load   = MUL_A;
        b_load   = MUL_B;
        neg_load = 1'b0;
        if (MUL_SIGNED) begin
            a_load   = MUL_A[15] ? (~MUL_A + 16'd1) : MUL_A;
            b_load   = MUL_B[15] ? (~MUL_B + 16'd1) : MUL_B;
            neg_load = MUL_A[15] ^ MUL_B[15];
        end
    end
`else
    logic unused_mul_signed;
    assign unused_mul_signed = MUL_SIGNED;

    always_comb begin
        a_load   = MUL_A;
        b_load   = MUL_B;
        neg_load = 1'b0;
    end
`endif

    // Carry-out of the unsigned 16-bit add, recovered from the wrapped result.
    assign carry    = (ALU_R < p_hi_q);
    assign prod_raw = {carry, ALU_R, p_lo_q[15:1]};
    assign prod_fin = neg_q ? (~prod_raw + 32'd1) : prod_raw;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            StIdle: begin
                if (MUL_START) begin
                    state_d = StRun;
                    a_d     = a_load;
                    p_hi_d  = 16'h0000;
                    p_lo_d  = b_load;
                    cnt_d   = 4'd0;
                    neg_d   = neg_load;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                p_hi_d = prod_raw[31:16];
                p_lo_d = prod_raw[15:0];
                cnt_d  = cnt_q + 4'd1;
                busy_d = 1'b1;
                if (cnt_q == 4'd15) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = prod_fin[31:16];
                    lo_d    = prod_fin[15:0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            a_q     <= 16'h0000;
            p_hi_q  <= 16'h0000;
            p_lo_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 16'h0000;
            lo_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ALU-side mux: multiplier owns the ALU only while running.
    always_comb begin
        ALU_OPX    = CORE_OPX;
        ALUA_SRCX  = CORE_ASRCX;
        ALUB_SRCX  = CORE_BSRCX;
        ALUA_DIN   = CORE_ADIN;
        ALUB_DIN   = CORE_BDIN;
        CCL_LD     = CORE_CCL_LD;
        CORE_STALL = 1'b0;
        if (state_q == StRun) begin
            ALU_OPX    = ALU_OP_ADD;
            ALUA_SRCX  = ASRC_DIN;
            ALUB_SRCX  = BSRC_DIN;
            ALUA_DIN   = p_hi_q;
            ALUB_DIN   = p_lo_q[0] ? a_q : 16'h0000;
            CCL_LD     = 1'b0;
            CORE_STALL = CORE_VALID;
        end
    end

    assign MUL_BUSY = busy_q;
    assign MUL_DONE = done_q;
    assign MUL_HI   = hi_q;
    assign MUL_LO   = lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer with a behavioural ALU model.
// Signed-mode vectors are compiled in only when MUL_SIGNED_EN is defined.
module tb_alu_mul_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CORE_VALID;
    logic [3:0]  CORE_OPX;
    logic [1:0]  CORE_ASRCX;
    logic [2:0]  CORE_BSRCX;
    logic [15:0] CORE_ADIN;
    logic [15:0] CORE_BDIN;
    logic        CORE_CCL_LD;
    logic        CORE_STALL;
    logic        MUL_START;
    logic        MUL_SIGNED;
    logic [15:0] MUL_A;
    logic [15:0] MUL_B;
    logic        MUL_BUSY;
    logic        MUL_DONE;
    logic [15:0] MUL_HI;
    logic [15:0] MUL_LO;
    logic [3:0]  ALU_OPX;
    logic [1:0]  ALUA_SRCX;
    logic [2:0]  ALUB_SRCX;
    logic [15:0] ALUA_DIN;
    logic [15:0] ALUB_DIN;
    logic        CCL_LD;
    logic [15:0] ALU_R;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // ALU model: ADD only for the DIN/DIN selection, anything else gives a distinct value.
    always_comb begin
        if (ALU_OPX == 4'h0 && ALUA_SRCX == 2'b00 && ALUB_SRCX == 3'b000)
            ALU_R = ALUA_DIN + ALUB_DIN;
        else
            ALU_R = (ALUA_DIN ^ ALUB_DIN) ^ 16'h5A5A;
    end

    alu_mul_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CORE_VALID  (CORE_VALID),
        .CORE_OPX    (CORE_OPX),
        .CORE_ASRCX  (CORE_ASRCX),
        .CORE_BSRCX  (CORE_BSRCX),
        .CORE_ADIN   (CORE_ADIN),
        .CORE_BDIN   (CORE_BDIN),
        .CORE_CCL_LD (CORE_CCL_LD),
        .CORE_STALL  (CORE_STALL),
        .MUL_START   (MUL_START),
        .MUL_SIGNED  (MUL_SIGNED),
        .MUL_A       (MUL_A),
        .MUL_B       (MUL_B),
        .MUL_BUSY    (MUL_BUSY),
        .MUL_DONE    (MUL_DONE),
        .MUL_HI      (MUL_HI),
        .MUL_LO      (MUL_LO),
        .ALU_OPX     (ALU_OPX),
        .ALUA_SRCX   (ALUA_SRCX),
        .ALUB_SRCX   (ALUB_SRCX),
        .ALUA_DIN    (ALUA_DIN),
        .ALUB_DIN    (ALUB_DIN),
        .CCL_LD      (CCL_LD),
        .ALU_R       (ALU_R)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Caller is mid-cycle in IDLE; START is presented this cycle (cycle 0).
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input logic [31:0] exp);
        logic busy_ok;
        busy_ok    = 1'b1;
        MUL_A      = a;
        MUL_B      = b;
        MUL_SIGNED = sgn;
        MUL_START  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            MUL_START = 1'b0;
            #1;
            if (!(MUL_BUSY === 1'b1 && MUL_DONE === 1'b0)) busy_ok = 1'b0;
        end
        chk({tag, " busy 1..16"}, {31'd0, busy_ok}, 32'd1);
        tick();
        #1;
        chk({tag, " done c17"}, {30'd0, MUL_BUSY, MUL_DONE}, 32'd1);
        chk({tag, " product"}, {MUL_HI, MUL_LO}, exp);
        tick();
        #1;
        chk({tag, " held c18"}, {14'd0, MUL_BUSY, MUL_DONE, MUL_HI, MUL_LO}, {16'd0, exp});
    endtask

    initial begin
        logic flag;
        RESET       = 1'b1;
        CORE_VALID  = 1'b1;
        CORE_OPX    = 4'h9;
        CORE_ASRCX  = 2'b10;
        CORE_BSRCX  = 3'b101;
        CORE_ADIN   = 16'h1357;
        CORE_BDIN   = 16'h2468;
        CORE_CCL_LD = 1'b1;
        MUL_START   = 1'b0;
        MUL_SIGNED  = 1'b0;
        MUL_A       = 16'h0000;
        MUL_B       = 16'h0000;
        #3;
        chk("reset status", {12'd0, MUL_BUSY, MUL_DONE, CORE_STALL, 1'b0, MUL_HI, MUL_LO}, 32'd0);
        chk("reset passthru", {ALU_OPX, ALUA_SRCX, ALUB_SRCX, CCL_LD, ALUA_DIN, ALUB_DIN[5:0]},
            {4'h9, 2'b10, 3'b101, 1'b1, 16'h1357, 6'h28});
        tick();
        RESET = 1'b0;
        tick();

        // 3 x 5 with START and a core request in the same cycle, then core held during RUN.
        CORE_OPX   = 4'hA;
        CORE_ASRCX = 2'b01;
        CORE_BSRCX = 3'b011;
        MUL_A      = 16'h0003;
        MUL_B      = 16'h0005;
        MUL_START  = 1'b1;
        #1;
        chk("c0 passthru", {ALU_OPX, ALUA_SRCX, ALUB_SRCX, CCL_LD, CORE_STALL, MUL_BUSY},
            {4'hA, 2'b01, 3'b011, 1'b1, 1'b0, 1'b0});
        tick();
        MUL_START = 1'b0;
        #1;
        chk("c1 run ctl", {ALU_OPX, ALUA_SRCX, ALUB_SRCX, CCL_LD, CORE_STALL, MUL_BUSY},
            {4'h0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1});
        chk("c1 run din", {ALUA_DIN, ALUB_DIN}, {16'h0000, 16'h0003});
        tick();
        CORE_VALID = 1'b0;
        #1;
        chk("c2 no stall", {31'd0, CORE_STALL}, 32'd0);
        chk("c2 din", {ALUA_DIN, ALUB_DIN}, {16'h0001, 16'h0000});
        CORE_VALID = 1'b1;
        tick();
        tick();
        tick();
        // Cycle 5: a second START with different operands must be ignored.
        MUL_A     = 16'h0007;
        MUL_B     = 16'h0009;
        MUL_START = 1'b1;
        tick();
        MUL_START = 1'b0;
        flag      = 1'b1;
        for (int c = 6; c <= 16; c++) begin
            #1;
            if (!(MUL_BUSY === 1'b1 && MUL_DONE === 1'b0 && CORE_STALL === 1'b1)) flag = 1'b0;
            tick();
        end
        #1;
        chk("3x5 done c17", {29'd0, MUL_BUSY, MUL_DONE, CORE_STALL}, 32'd2);
        chk("3x5 busy 6..16", {31'd0, flag}, 32'd1);
        chk("3x5 product", {MUL_HI, MUL_LO}, 32'h0000_000F);
        chk("c17 passthru", {ALU_OPX, CCL_LD}, {4'hA, 1'b1});
        tick();
        #1;
        chk("c18 idle", {29'd0, MUL_BUSY, MUL_DONE, CORE_STALL}, 32'd0);
        chk("c18 not restarted", {ALU_OPX, ALUA_DIN}, {4'hA, 16'h1357});
        CORE_VALID  = 1'b0;
        CORE_CCL_LD = 1'b0;
        tick();

        do_mul("ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        do_mul("8000x0002", 16'h8000, 16'h0002, 1'b0, 32'h0001_0000);
        do_mul("1234x5678", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
        do_mul("fffdx0005 u", 16'hFFFD, 16'h0005, 1'b0, 32'h0004_FFF1);
`ifdef MUL_SIGNED_EN
        do_mul("fffdx0005 s", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
        do_mul("fffdxfffb s", 16'hFFFD, 16'hFFFB, 1'b1, 32'h0000_000F);
        do_mul("8000x0002 s", 16'h8000, 16'h0002, 1'b1, 32'hFFFF_0000);
`else
        do_mul("fffdx0005 ign", 16'hFFFD, 16'h0005, 1'b1, 32'h0004_FFF1);
`endif

        // Reset during cycle 8 of RUN aborts without a DONE pulse.
        MUL_A      = 16'h0101;
        MUL_B      = 16'h0202;
        MUL_SIGNED = 1'b0;
        MUL_START  = 1'b1;
        tick();
        MUL_START = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        #1;
        chk("pre-reset busy", {31'd0, MUL_BUSY}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("abort status", {14'd0, MUL_BUSY, MUL_DONE, MUL_HI, MUL_LO}, 32'd0);
        tick();
        RESET = 1'b0;
        flag  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (MUL_DONE !== 1'b0 || MUL_BUSY !== 1'b0) flag = 1'b0;
        end
        chk("no done after abort", {31'd0, flag}, 32'd1);
        do_mul("post-reset", 16'h00FF, 16'h0101, 1'b0, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
